// File: rtl/c2h_frame_ring_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// c2h_frame_ring_ctrl_pkg
// Ring geometry defaults and FSM state encoding shared by the C2H/H2C ring
// controllers and the register file, so every consumer sees the same values.
// Contents:
//   RING_BUF_START / RING_BUF_END / RING_FRM_SIZE : default ring geometry
//   ring_state_t                                  : frame FSM state encoding
//   ptr_is_legal()                                : host pointer range/alignment check
// -----------------------------------------------------------------------------
package c2h_frame_ring_ctrl_pkg;

   localparam logic [31:0] RING_BUF_START = 32'h0000_0000;
   localparam logic [31:0] RING_BUF_END   = 32'h1000_0000;
   localparam logic [31:0] RING_FRM_SIZE  = 32'd2048;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CHECK   = 2'd1,
      ST_BUSY    = 2'd2,
      ST_ADVANCE = 2'd3
   } ring_state_t;

   // A pointer is usable only if it lands inside the ring on a slot boundary.
   function automatic logic ptr_is_legal(input logic [31:0] ptr,
                                         input logic [31:0] buf_start,
                                         input logic [31:0] buf_end,
                                         input logic [31:0] frm_size);
      logic [31:0] off;
      off = ptr - buf_start;
      return (ptr >= buf_start) && (ptr < buf_end) && ((off % frm_size) == 32'd0);
   endfunction

endpackage

// File: rtl/c2h_frame_ring_ctrl_ring_ptr_inc.sv
// -----------------------------------------------------------------------------
// ring_ptr_inc
// Advances a ring pointer by one frame slot, wrapping to the ring start when the
// result reaches the exclusive end. Shared by the C2H and H2C ring controllers.
// Ports:
//   ptr : current slot address
//   nxt : following slot address (wrapped)
// -----------------------------------------------------------------------------
module ring_ptr_inc
   import c2h_frame_ring_ctrl_pkg::*;
#(
   parameter logic [31:0] BUF_START = RING_BUF_START,
   parameter logic [31:0] BUF_END   = RING_BUF_END,
   parameter logic [31:0] FRM_SIZE  = RING_FRM_SIZE
) (
   input  logic [31:0] ptr,
   output logic [31:0] nxt
);

   // 33-bit sum so a ring ending at the top of the address space cannot alias.
   logic [32:0] sum;

   assign sum = {1'b0, ptr} + {1'b0, FRM_SIZE};
   assign nxt = (sum >= {1'b0, BUF_END}) ? BUF_START : sum[31:0];

endmodule

// File: rtl/c2h_frame_ring_ctrl.sv
// -----------------------------------------------------------------------------
// c2h_frame_ring_ctrl
// Hands out card-to-host frame slots from a ring in host memory. The producer
// requests a slot, gets it acked (or dropped / stalled when the ring is full),
// writes it, signals done, and the write pointer advances one slot.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no request in flight, waiting for frm_req
// CHECK   | request seen, deciding grant / drop / stall from ring_full
// BUSY    | slot granted, producer writing, waiting for frm_done
// ADVANCE | slot finished, wr_ptr moves to the next slot
//
// Ports:
//   s_axi_aclk, s_axi_aresetn : clock, async active-low reset
//   frm_req / frm_ack / frm_drop / frm_addr / frm_done : producer handshake
//   C2H_RD_NEXT  : host read pointer from the register file
//   C2H_WR_NEXT  : next slot to be written, back to the register file
//   ring_full, ring_empty : ring status
//   drop_cnt     : saturating dropped-frame count
//   rd_ptr_err   : sticky, host wrote an out-of-range or misaligned pointer
// -----------------------------------------------------------------------------
module c2h_frame_ring_ctrl
   import c2h_frame_ring_ctrl_pkg::*;
#(
   parameter logic [31:0] BUF_START = RING_BUF_START,
   parameter logic [31:0] BUF_END   = RING_BUF_END,
   parameter logic [31:0] FRM_SIZE  = RING_FRM_SIZE,
   parameter bit          DROP_EN   = 1'b1
) (
   input  logic        s_axi_aclk,
   input  logic        s_axi_aresetn,
   input  logic        frm_req,
   output logic        frm_ack,
   output logic        frm_drop,
   output logic [31:0] frm_addr,
   input  logic        frm_done,
   input  logic [31:0] C2H_RD_NEXT,
   output logic [31:0] C2H_WR_NEXT,
   output logic        ring_full,
   output logic        ring_empty,
   output logic [15:0] drop_cnt,
   output logic        rd_ptr_err
);

   ring_state_t state_q;
   ring_state_t state_d;
   logic [31:0] wr_ptr_q;
   logic [31:0] rd_ptr_q;
   logic [31:0] wr_nxt;
   logic        rd_legal;
   logic        ack_d;
   logic        drop_d;
   logic        adv;

   ring_ptr_inc #(
      .BUF_START (BUF_START),
      .BUF_END   (BUF_END),
      .FRM_SIZE  (FRM_SIZE)
   ) u_wr_inc (
      .ptr (wr_ptr_q),
      .nxt (wr_nxt)
   );

   assign rd_legal    = ptr_is_legal(C2H_RD_NEXT, BUF_START, BUF_END, FRM_SIZE);
   assign ring_empty  = (wr_ptr_q == rd_ptr_q);
   // One slot is always left unused so full and empty stay distinguishable.
   assign ring_full   = (wr_nxt == rd_ptr_q);
   assign C2H_WR_NEXT = wr_ptr_q;

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      drop_d  = 1'b0;
      adv     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (frm_req) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (!ring_full) begin
               ack_d   = 1'b1;
               state_d = ST_BUSY;
            end else if (DROP_EN) begin
               drop_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (frm_done) state_d = ST_ADVANCE;
         end
         ST_ADVANCE: begin
            adv     = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= BUF_START;
         rd_ptr_q   <= BUF_START;
         rd_ptr_err <= 1'b0;
         frm_ack    <= 1'b0;
         frm_drop   <= 1'b0;
         frm_addr   <= BUF_START;
         drop_cnt   <= 16'd0;
      end else begin
         state_q  <= state_d;
         frm_ack  <= ack_d;
         frm_drop <= drop_d;
         // A bad host pointer is flagged and ignored; the last good one stays.
         if (rd_legal) rd_ptr_q   <= C2H_RD_NEXT;
         else          rd_ptr_err <= 1'b1;
         if (ack_d) frm_addr <= wr_ptr_q;
         if (adv)   wr_ptr_q <= wr_nxt;
         if (drop_d && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_c2h_frame_ring_ctrl.sv
module tb_c2h_frame_ring_ctrl;

   localparam logic [31:0] BSTART = 32'h0;
   localparam logic [31:0] BEND   = 32'h2000;
   localparam logic [31:0] FSZ    = 32'h800;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req   [2];
   logic        done  [2];
   logic [31:0] rd    [2];
   logic        ack_w [2];
   logic        drop_w[2];
   logic        full_w[2];
   logic        empty_w[2];
   logic        err_w [2];
   logic [31:0] addr_w[2];
   logic [31:0] wrn_w [2];
   logic [15:0] dcnt_w[2];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   // index 0: drop mode, index 1: stall mode
   c2h_frame_ring_ctrl #(.BUF_START(BSTART), .BUF_END(BEND), .FRM_SIZE(FSZ), .DROP_EN(1'b1)) dut_d (
      .s_axi_aclk(clk), .s_axi_aresetn(rstn),
      .frm_req(req[0]), .frm_ack(ack_w[0]), .frm_drop(drop_w[0]), .frm_addr(addr_w[0]),
      .frm_done(done[0]), .C2H_RD_NEXT(rd[0]), .C2H_WR_NEXT(wrn_w[0]),
      .ring_full(full_w[0]), .ring_empty(empty_w[0]), .drop_cnt(dcnt_w[0]), .rd_ptr_err(err_w[0]));

   c2h_frame_ring_ctrl #(.BUF_START(BSTART), .BUF_END(BEND), .FRM_SIZE(FSZ), .DROP_EN(1'b0)) dut_s (
      .s_axi_aclk(clk), .s_axi_aresetn(rstn),
      .frm_req(req[1]), .frm_ack(ack_w[1]), .frm_drop(drop_w[1]), .frm_addr(addr_w[1]),
      .frm_done(done[1]), .C2H_RD_NEXT(rd[1]), .C2H_WR_NEXT(wrn_w[1]),
      .ring_full(full_w[1]), .ring_empty(empty_w[1]), .drop_cnt(dcnt_w[1]), .rd_ptr_err(err_w[1]));

   // Reference ring arithmetic: slot after p, with wrap.
   function automatic logic [31:0] m_next(input logic [31:0] p);
      longint s;
      s = longint'(p) + longint'(FSZ);
      return (s >= longint'(BEND)) ? BSTART : 32'(s);
   endfunction

   function automatic bit m_legal(input logic [31:0] p);
      return (p >= BSTART) && (p < BEND) && (((p - BSTART) % FSZ) == 0);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; done[i] = 1'b0; rd[i] = BSTART;
      end
      tick();
      tick();
      rstn = 1'b1;
   endtask

   // One producer transaction: request, wait for ack/drop, then write and finish.
   task automatic frame(input int idx, input int done_dly, input bit chg, input logic [31:0] new_rd,
                        output bit got_ack, output bit got_drop, output int lat, output logic [31:0] addr);
      got_ack = 1'b0; got_drop = 1'b0; lat = 0; addr = 32'hDEAD_BEEF;
      req[idx] = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (ack_w[idx] || drop_w[idx]) begin
            lat = i; got_ack = ack_w[idx]; got_drop = drop_w[idx]; addr = addr_w[idx];
            break;
         end
      end
      req[idx] = 1'b0;
      if (got_ack) begin
         repeat (done_dly) tick();
         done[idx] = 1'b1;
         if (chg) rd[idx] = new_rd;
         tick();
         done[idx] = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; done[i] = 1'b0; rd[i] = BSTART;
      end
      #2;
      for (int i = 0; i < 2; i++) begin
         total++; if (ack_w[i] !== 1'b0) begin bad++; $display("FAIL reset_ack[%0d] got=%b exp=0", i, ack_w[i]); end
         total++; if (drop_w[i] !== 1'b0) begin bad++; $display("FAIL reset_drop[%0d] got=%b exp=0", i, drop_w[i]); end
         total++; if (addr_w[i] !== BSTART) begin bad++; $display("FAIL reset_addr[%0d] got=%h exp=%h", i, addr_w[i], BSTART); end
         total++; if (wrn_w[i] !== BSTART) begin bad++; $display("FAIL reset_wrnext[%0d] got=%h exp=%h", i, wrn_w[i], BSTART); end
         total++; if (empty_w[i] !== 1'b1) begin bad++; $display("FAIL reset_empty[%0d] got=%b exp=1", i, empty_w[i]); end
         total++; if (full_w[i] !== 1'b0) begin bad++; $display("FAIL reset_full[%0d] got=%b exp=0", i, full_w[i]); end
         total++; if (dcnt_w[i] !== 16'd0) begin bad++; $display("FAIL reset_dcnt[%0d] got=%0d exp=0", i, dcnt_w[i]); end
         total++; if (err_w[i] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", i, err_w[i]); end
      end
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_single();
      bit a, d; int lat; logic [31:0] ad;
      frame(0, 0, 1'b0, 32'h0, a, d, lat, ad);
      total++; if (a !== 1'b1 || d !== 1'b0) begin bad++; $display("FAIL single_ack got ack=%b drop=%b exp ack=1 drop=0", a, d); end
      total++; if (lat != 2) begin bad++; $display("FAIL single_latency got=%0d exp=2", lat); end
      total++; if (ad !== 32'h0) begin bad++; $display("FAIL single_addr got=%h exp=0", ad); end
      total++; if (wrn_w[0] !== 32'h800) begin bad++; $display("FAIL single_wrnext got=%h exp=800", wrn_w[0]); end
      total++; if (empty_w[0] !== 1'b0) begin bad++; $display("FAIL single_empty got=%b exp=0", empty_w[0]); end
   endtask

   task automatic test_fill_drop();
      bit a, d; int lat; logic [31:0] ad;
      for (int k = 1; k <= 2; k++) begin
         frame(0, k, 1'b0, 32'h0, a, d, lat, ad);
         total++; if (a !== 1'b1 || ad !== 32'(k) * FSZ) begin bad++; $display("FAIL fill_addr%0d got ack=%b addr=%h exp ack=1 addr=%h", k, a, ad, 32'(k) * FSZ); end
      end
      total++; if (full_w[0] !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full_w[0]); end
      total++; if (wrn_w[0] !== 32'h1800) begin bad++; $display("FAIL fill_wrnext got=%h exp=1800", wrn_w[0]); end
      frame(0, 0, 1'b0, 32'h0, a, d, lat, ad);
      total++; if (d !== 1'b1 || a !== 1'b0) begin bad++; $display("FAIL drop_pulse got ack=%b drop=%b exp ack=0 drop=1", a, d); end
      total++; if (dcnt_w[0] !== 16'd1) begin bad++; $display("FAIL drop_cnt got=%0d exp=1", dcnt_w[0]); end
      total++; if (wrn_w[0] !== 32'h1800) begin bad++; $display("FAIL drop_wrnext got=%h exp=1800", wrn_w[0]); end
   endtask

   task automatic test_wrap();
      bit a, d; int lat; logic [31:0] ad;
      rd[0] = 32'h1000;
      tick();
      frame(0, 0, 1'b0, 32'h0, a, d, lat, ad);
      total++; if (a !== 1'b1 || ad !== 32'h1800) begin bad++; $display("FAIL wrap_addr1 got ack=%b addr=%h exp ack=1 addr=1800", a, ad); end
      frame(0, 1, 1'b0, 32'h0, a, d, lat, ad);
      total++; if (a !== 1'b1 || ad !== 32'h0) begin bad++; $display("FAIL wrap_addr2 got ack=%b addr=%h exp ack=1 addr=0", a, ad); end
      total++; if (wrn_w[0] !== 32'h800) begin bad++; $display("FAIL wrap_wrnext got=%h exp=800", wrn_w[0]); end
      total++; if (full_w[0] !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", full_w[0]); end
   endtask

   task automatic test_illegal_ptr();
      // wr=800, rd_q=1000 here; accepting 804 would clear full.
      rd[0] = 32'h0804;
      tick();
      tick();
      total++; if (err_w[0] !== 1'b1) begin bad++; $display("FAIL illegal_misaligned_err got=%b exp=1", err_w[0]); end
      total++; if (full_w[0] !== 1'b1) begin bad++; $display("FAIL illegal_misaligned_keep got full=%b exp=1", full_w[0]); end
      do_reset();
      rd[0] = 32'h2000;
      tick();
      tick();
      total++; if (err_w[0] !== 1'b1) begin bad++; $display("FAIL illegal_range_err got=%b exp=1", err_w[0]); end
      total++; if (empty_w[0] !== 1'b1) begin bad++; $display("FAIL illegal_range_keep got empty=%b exp=1", empty_w[0]); end
      rd[0] = BSTART;
   endtask

   task automatic test_stall();
      bit a, d; int lat; logic [31:0] ad;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         frame(1, 0, 1'b0, 32'h0, a, d, lat, ad);
         total++; if (a !== 1'b1 || ad !== 32'(k) * FSZ) begin bad++; $display("FAIL stall_fill%0d got ack=%b addr=%h exp ack=1 addr=%h", k, a, ad, 32'(k) * FSZ); end
      end
      total++; if (full_w[1] !== 1'b1) begin bad++; $display("FAIL stall_full got=%b exp=1", full_w[1]); end
      req[1] = 1'b1;
      for (int t = 0; t < 6; t++) begin
         tick();
         total++; if (ack_w[1] !== 1'b0 || drop_w[1] !== 1'b0) begin bad++; $display("FAIL stall_hold t=%0d got ack=%b drop=%b exp 0 0", t, ack_w[1], drop_w[1]); end
      end
      rd[1] = 32'h800;
      tick();
      total++; if (ack_w[1] !== 1'b0) begin bad++; $display("FAIL stall_early_ack got=%b exp=0", ack_w[1]); end
      tick();
      total++; if (ack_w[1] !== 1'b1 || addr_w[1] !== 32'h1800) begin bad++; $display("FAIL stall_release got ack=%b addr=%h exp ack=1 addr=1800", ack_w[1], addr_w[1]); end
      req[1] = 1'b0;
      done[1] = 1'b1;
      tick();
      done[1] = 1'b0;
      tick();
      total++; if (wrn_w[1] !== 32'h0) begin bad++; $display("FAIL stall_wrnext got=%h exp=0", wrn_w[1]); end
      total++; if (dcnt_w[1] !== 16'd0) begin bad++; $display("FAIL stall_dcnt got=%0d exp=0", dcnt_w[1]); end
   endtask

   task automatic test_reset_mid_frame();
      bit a, d; int lat; logic [31:0] ad;
      do_reset();
      req[0] = 1'b1;
      tick();
      tick();
      total++; if (ack_w[0] !== 1'b1) begin bad++; $display("FAIL midrst_ack got=%b exp=1", ack_w[0]); end
      req[0] = 1'b0;
      #2;
      rstn = 1'b0;
      #1;
      total++; if (wrn_w[0] !== 32'h0 || empty_w[0] !== 1'b1) begin bad++; $display("FAIL midrst_async got wrnext=%h empty=%b exp 0 1", wrn_w[0], empty_w[0]); end
      total++; if (ack_w[0] !== 1'b0 || addr_w[0] !== BSTART) begin bad++; $display("FAIL midrst_outs got ack=%b addr=%h exp 0 0", ack_w[0], addr_w[0]); end
      tick();
      rstn = 1'b1;
      done[0] = 1'b1;
      tick();
      done[0] = 1'b0;
      tick();
      tick();
      total++; if (wrn_w[0] !== 32'h0 || empty_w[0] !== 1'b1) begin bad++; $display("FAIL midrst_done_ignored got wrnext=%h empty=%b exp 0 1", wrn_w[0], empty_w[0]); end
      frame(0, 0, 1'b0, 32'h0, a, d, lat, ad);
      total++; if (a !== 1'b1 || lat != 2 || ad !== 32'h0) begin bad++; $display("FAIL midrst_idle got ack=%b lat=%0d addr=%h exp 1 2 0", a, lat, ad); end
   endtask

   function automatic logic [31:0] pick_ptr();
      logic [31:0] p;
      p = 32'($urandom_range(0, 3)) * FSZ;
      if ($urandom_range(0, 15) == 0) p = ($urandom_range(0, 1) == 0) ? BEND : p + 32'h4;
      return p;
   endfunction

   task automatic test_random();
      logic [31:0] m_wr, m_rd, p, np, ad;
      int m_cnt; bit m_err, exp_full, chg, a, d; int lat;
      do_reset();
      m_wr = BSTART; m_rd = BSTART; m_cnt = 0; m_err = 1'b0;
      for (int it = 0; it < 50; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            p = pick_ptr();
            rd[0] = p;
            tick();
            if (m_legal(p)) m_rd = p; else m_err = 1'b1;
         end
         chg = 1'($urandom_range(0, 1));
         np = pick_ptr();
         exp_full = (m_next(m_wr) == m_rd);
         frame(0, $urandom_range(0, 3), chg, np, a, d, lat, ad);
         total++; if (a !== !exp_full || d !== exp_full || lat != 2) begin bad++; $display("FAIL rand_outcome it=%0d got ack=%b drop=%b lat=%0d exp ack=%b drop=%b lat=2", it, a, d, lat, !exp_full, exp_full); end
         if (!exp_full) begin
            total++; if (ad !== m_wr) begin bad++; $display("FAIL rand_addr it=%0d got=%h exp=%h", it, ad, m_wr); end
            m_wr = m_next(m_wr);
            if (chg) begin
               if (m_legal(np)) m_rd = np; else m_err = 1'b1;
            end
         end else begin
            m_cnt++;
         end
         total++; if (wrn_w[0] !== m_wr) begin bad++; $display("FAIL rand_wrnext it=%0d got=%h exp=%h", it, wrn_w[0], m_wr); end
         total++; if (empty_w[0] !== (m_wr == m_rd) || full_w[0] !== (m_next(m_wr) == m_rd)) begin bad++; $display("FAIL rand_status it=%0d got empty=%b full=%b exp empty=%b full=%b", it, empty_w[0], full_w[0], m_wr == m_rd, m_next(m_wr) == m_rd); end
         total++; if (dcnt_w[0] !== 16'(m_cnt) || err_w[0] !== m_err) begin bad++; $display("FAIL rand_cnt_err it=%0d got cnt=%0d err=%b exp cnt=%0d err=%b", it, dcnt_w[0], err_w[0], m_cnt, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drop();
      test_wrap();
      test_illegal_ptr();
      test_stall();
      test_reset_mid_frame();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/c2h_frame_ring_ctrl.md
C2H_FRAME_RING_CTRL -- requirements
Module: c2h_frame_ring_ctrl

Interface
REQ-001 The block SHALL have parameter BUF_START, default 32'h0000_0000, meaning the first byte address of the C2H frame ring.
REQ-002 The block SHALL have parameter BUF_END, default 32'h1000_0000, meaning the exclusive end address of the ring.
REQ-003 The block SHALL have parameter FRM_SIZE, default 32'd2048, meaning the bytes per frame slot.
REQ-004 The block SHALL have parameter DROP_EN, default 1, meaning 1 = drop a frame when the ring is full and 0 = stall the request.
REQ-005 The block SHALL have port s_axi_aclk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port s_axi_aresetn, input, 1 bit: the asynchronous active-low reset.
REQ-007 The block SHALL have port frm_req, input, 1 bit: the producer requests a frame slot; held high until it sees frm_ack or frm_drop.
REQ-008 The block SHALL have port frm_ack, output, 1 bit: a one-cycle pulse granting the slot at frm_addr.
REQ-009 The block SHALL have port frm_drop, output, 1 bit: a one-cycle pulse refusing the request because the ring is full.
REQ-010 The block SHALL have port frm_addr, output, 32 bits: the slot start address, valid from frm_ack until frm_done.
REQ-011 The block SHALL have port frm_done, input, 1 bit: a one-cycle pulse indicating the producer finished writing the granted slot.
REQ-012 The block SHALL have port C2H_RD_NEXT, input, 32 bits: the host read pointer from the register file.
REQ-013 The block SHALL have port C2H_WR_NEXT, output, 32 bits: the next slot to be written, fed back to the register file.
REQ-014 The block SHALL have ports ring_full and ring_empty, output, 1 bit each: the ring status.
REQ-015 The block SHALL have port drop_cnt, output, 16 bits: a saturating count of dropped frames.
REQ-016 The block SHALL have port rd_ptr_err, output, 1 bit: a sticky flag for an illegal host read pointer.

Function
REQ-017 The block SHALL register C2H_RD_NEXT every cycle into rd_ptr_q and SHALL use only rd_ptr_q for full/empty decisions, giving 1 cycle of latency.
REQ-018 A sampled pointer that is outside [BUF_START, BUF_END) or whose offset from BUF_START is not a multiple of FRM_SIZE SHALL set rd_ptr_err, and the block SHALL then keep the previous rd_ptr_q.
REQ-019 The block SHALL compute nxt = wr_ptr + FRM_SIZE in 33-bit arithmetic, and nxt >= BUF_END SHALL wrap to BUF_START.
REQ-020 ring_empty SHALL equal (wr_ptr == rd_ptr_q), and ring_full SHALL equal (nxt(wr_ptr) == rd_ptr_q), so one slot always stays unused.
REQ-021 The FSM states SHALL be IDLE, CHECK, BUSY and ADVANCE.
REQ-022 IDLE SHALL move to CHECK when frm_req is 1.
REQ-023 CHECK with ring_full = 0 SHALL pulse frm_ack, drive frm_addr = wr_ptr, and go to BUSY.
REQ-024 CHECK with ring_full = 1 and DROP_EN = 1 SHALL pulse frm_drop, increment drop_cnt (saturating at 16'hFFFF), and go to IDLE.
REQ-025 CHECK with ring_full = 1 and DROP_EN = 0 SHALL remain in CHECK with no pulse.
REQ-026 BUSY SHALL wait for frm_done and then go to ADVANCE.
REQ-027 ADVANCE SHALL set wr_ptr = nxt(wr_ptr) and go to IDLE, making the request-to-ack latency 2 cycles and the back-to-back frame period 4 cycles minimum.
REQ-028 frm_done outside BUSY SHALL be ignored.
REQ-029 A frm_done arriving in the same cycle as a C2H_RD_NEXT change SHALL be handled with both taking effect, the pointer being seen next cycle.
REQ-030 C2H_WR_NEXT SHALL equal wr_ptr and SHALL update only in ADVANCE.
REQ-031 frm_ack and frm_drop SHALL never be high in the same cycle.

Reset
REQ-032 Asserting s_axi_aresetn low at any time, including in BUSY, SHALL immediately force state = IDLE, wr_ptr = BUF_START, rd_ptr_q = BUF_START, frm_ack = 0, frm_drop = 0, frm_addr = BUF_START, drop_cnt = 0 and rd_ptr_err = 0, giving ring_empty = 1 and ring_full = 0.
REQ-033 A slot granted before reset SHALL be discarded, with no ADVANCE after reset.

Structure
REQ-034 The ring defaults (start, end, frame size) SHALL live in a shared package, together with the FSM state encoding, so the register file and this block read identical constants.
REQ-035 The pointer-increment-with-wrap function SHALL be a sub-module ring_ptr_inc (inputs ptr, outputs nxt), reused for the H2C ring.
REQ-036 No other sub-modules SHALL be used.

Verification
REQ-037 The bench SHALL use BUF_START = 0, BUF_END = 'h2000 and FRM_SIZE = 'h800 (4 slots).
REQ-038 Single frame from reset: req at cycle 0 SHALL give ack at cycle 2 with frm_addr = 0; done then SHALL give C2H_WR_NEXT = 'h800 and ring_empty = 0.
REQ-039 Fill: 3 frames with RD_NEXT = 0 SHALL give ring_full = 1 and C2H_WR_NEXT = 'h1800; a 4th request with DROP_EN = 1 SHALL give frm_drop, drop_cnt = 1 and wr_ptr unchanged.
REQ-040 Wrap: after RD_NEXT is set to 'h1000 and 2 more frames are written, addresses SHALL be 'h1800 then 0, and C2H_WR_NEXT SHALL be 'h800.
REQ-041 Stall mode: with DROP_EN = 0 and the ring full, req SHALL be held in CHECK; moving RD_NEXT forward one slot SHALL give ack 2 cycles later.
REQ-042 An illegal pointer: RD_NEXT = 'h0804 or 'h2000 SHALL set rd_ptr_err = 1 and leave rd_ptr_q unchanged.
REQ-043 Reset mid-frame: aresetn low in BUSY SHALL give state IDLE, C2H_WR_NEXT = 0, ring_empty = 1, and a later frm_done SHALL be ignored.
